// File: rtl/frame_sig_rx_if.sv
// Pixel-stream and signature-record bundle for frame_sig_rx.
// No timing of its own; it only groups signals.
// The pixel side has no backpressure; the record side is valid/ready.
interface frame_sig_rx_if #(
  parameter int CORDW = 16
);
  // pixel stream from the video timing / game top level
  logic signed [CORDW-1:0] in_sx;
  logic signed [CORDW-1:0] in_sy;
  logic                    in_de;
  logic                    in_frame;
  logic [7:0]              in_r;
  logic [7:0]              in_g;
  logic [7:0]              in_b;

  // per-frame signature record
  logic                    sig_valid;
  logic                    sig_ready;
  logic [15:0]             sig_crc;
  logic [19:0]             sig_pix_cnt;
  logic [15:0]             sig_frame_no;
  logic                    sig_geom_err;
  logic                    sig_coord_err;
  logic                    sig_overrun;

  // pixel source and record consumer (harness side)
  modport master (
    output in_sx, in_sy, in_de, in_frame, in_r, in_g, in_b, sig_ready,
    input  sig_valid, sig_crc, sig_pix_cnt, sig_frame_no,
           sig_geom_err, sig_coord_err, sig_overrun
  );

  // signature block side
  modport slave (
    input  in_sx, in_sy, in_de, in_frame, in_r, in_g, in_b, sig_ready,
    output sig_valid, sig_crc, sig_pix_cnt, sig_frame_no,
           sig_geom_err, sig_coord_err, sig_overrun
  );
endinterface

// File: rtl/frame_sig_rx.sv
// Per-frame signature sink: CRC-16-CCITT over active RGB, pixel count, geometry/coord flags.
// Record appears 1 cycle after the in_frame that closes a frame; all outputs registered.
// Input never stalls; a record arriving while the previous one is unaccepted is dropped and flagged in sig_overrun.
// Optional macro FRAME_SIG_COORD_CHECK_EN builds the expected-coordinate tracker.
module frame_sig_rx #(
  parameter int CORDW = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic           clk_pix,
  input  logic           rst_pix_n,
  frame_sig_rx_if.slave  bus
);

  localparam logic [19:0] EXP_PIX = 20'(H_RES * V_RES);

  typedef enum logic {WAIT_SOF, ACCUM} state_t;

  state_t      state;
  logic [15:0] crc_acc;
  logic [19:0] cnt_acc;
  logic [15:0] frame_cnt;

  logic        sig_valid_q;
  logic [15:0] sig_crc_q;
  logic [19:0] sig_pix_cnt_q;
  logic [15:0] sig_frame_no_q;
  logic        sig_geom_err_q;
  logic        sig_overrun_q;

  logic        frame_end;
  logic        load_rec;
  logic        pix_take;
  logic [15:0] crc_base;
  logic [15:0] crc_next;
  logic [19:0] cnt_base;
  logic [19:0] cnt_next;

  // CRC-16-CCITT (0x1021), all 24 pixel bits folded MSB first in one cycle
  function automatic logic [15:0] crc16_pix(input logic [15:0] crc_in, input logic [23:0] pix);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ pix[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // in_frame restarts the accumulators; a pixel in that same cycle belongs to the new frame
  always_comb begin
    frame_end = bus.in_frame && (state == ACCUM);
    load_rec  = frame_end && (!sig_valid_q || bus.sig_ready);
    pix_take  = bus.in_de && (bus.in_frame || (state == ACCUM));
    crc_base  = bus.in_frame ? 16'hFFFF : crc_acc;
    cnt_base  = bus.in_frame ? 20'd0 : cnt_acc;
    crc_next  = pix_take ? crc16_pix(crc_base, {bus.in_r, bus.in_g, bus.in_b}) : crc_base;
    cnt_next  = (pix_take && (cnt_base != 20'hFFFFF)) ? cnt_base + 20'd1 : cnt_base;
  end

`ifdef FRAME_SIG_COORD_CHECK_EN
  localparam logic signed [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);

  logic signed [CORDW-1:0] exp_x;
  logic signed [CORDW-1:0] exp_y;
  logic signed [CORDW-1:0] ex_base;
  logic signed [CORDW-1:0] ey_base;
  logic signed [CORDW-1:0] ex_next;
  logic signed [CORDW-1:0] ey_next;
  logic                    cerr_acc;
  logic                    cerr_base;
  logic                    cerr_next;
  logic                    sig_coord_err_q;

  // raster-order expected position; any active pixel off that position flags the frame
  always_comb begin
    ex_base   = bus.in_frame ? '0 : exp_x;
    ey_base   = bus.in_frame ? '0 : exp_y;
    cerr_base = bus.in_frame ? 1'b0 : cerr_acc;
    ex_next   = ex_base;
    ey_next   = ey_base;
    cerr_next = cerr_base;
    if (pix_take) begin
      if ((bus.in_sx != ex_base) || (bus.in_sy != ey_base)) cerr_next = 1'b1;
      if (ex_base == X_LAST) begin
        ex_next = '0;
        ey_next = ey_base + CORDW'(1);
      end else begin
        ex_next = ex_base + CORDW'(1);
      end
    end
  end

  assign bus.sig_coord_err = sig_coord_err_q;
`else
  logic unused_coord;
  assign unused_coord      = ^{bus.in_sx, bus.in_sy};
  assign bus.sig_coord_err = 1'b0;
`endif

  // frame FSM, accumulators and the output record register with valid/ready hold
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state          <= WAIT_SOF;
      crc_acc        <= 16'd0;
      cnt_acc        <= 20'd0;
      frame_cnt      <= 16'd0;
      sig_valid_q    <= 1'b0;
      sig_crc_q      <= 16'd0;
      sig_pix_cnt_q  <= 20'd0;
      sig_frame_no_q <= 16'd0;
      sig_geom_err_q <= 1'b0;
      sig_overrun_q  <= 1'b0;
`ifdef FRAME_SIG_COORD_CHECK_EN
      exp_x           <= '0;
      exp_y           <= '0;
      cerr_acc        <= 1'b0;
      sig_coord_err_q <= 1'b0;
`endif
    end else begin
      if (bus.in_frame) state <= ACCUM;

      if (bus.in_frame || (state == ACCUM)) begin
        crc_acc <= crc_next;
        cnt_acc <= cnt_next;
`ifdef FRAME_SIG_COORD_CHECK_EN
        exp_x    <= ex_next;
        exp_y    <= ey_next;
        cerr_acc <= cerr_next;
`endif
      end

      // frame number advances on every closed frame, delivered or dropped
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;

      if (load_rec) begin
        sig_valid_q    <= 1'b1;
        sig_crc_q      <= crc_acc;
        sig_pix_cnt_q  <= cnt_acc;
        sig_frame_no_q <= frame_cnt;
        sig_geom_err_q <= (cnt_acc != EXP_PIX);
`ifdef FRAME_SIG_COORD_CHECK_EN
        sig_coord_err_q <= cerr_acc;
`endif
      end else if (sig_valid_q && bus.sig_ready) begin
        sig_valid_q <= 1'b0;
      end

      if (frame_end && !load_rec) sig_overrun_q <= 1'b1;
    end
  end

  assign bus.sig_valid    = sig_valid_q;
  assign bus.sig_crc      = sig_crc_q;
  assign bus.sig_pix_cnt  = sig_pix_cnt_q;
  assign bus.sig_frame_no = sig_frame_no_q;
  assign bus.sig_geom_err = sig_geom_err_q;
  assign bus.sig_overrun  = sig_overrun_q;

endmodule

// File: tb/tb_frame_sig_rx.sv
// Bench for frame_sig_rx on a reduced 16x8 raster: scoreboard of expected records plus per-scenario checks.
// Records are predicted while pixels are driven and compared when the DUT hands them over.
// Honours FRAME_SIG_COORD_CHECK_EN for the expected coordinate flag.
module tb_frame_sig_rx;

  localparam int CORDW = 16;
  localparam int H     = 16;
  localparam int V     = 8;
  localparam int HV    = H * V;
`ifdef FRAME_SIG_COORD_CHECK_EN
  localparam bit COORD_EN = 1'b1;
`else
  localparam bit COORD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] crc;
    logic [19:0] cnt;
    logic [15:0] fno;
    logic        geom;
    logic        coord;
  } rec_t;

  logic clk_pix;
  logic rst_pix_n;
  int   checks;
  int   errors;

  rec_t exp_q[$];
  rec_t m_last;
  rec_t mon_exp;
  rec_t mon_got;

  // bench model of the frame accumulators
  bit          m_active;
  logic [15:0] m_crc;
  int          m_cnt;
  bit          m_cerr;
  int          m_frame_no;
  bit          push_on_end;

  frame_sig_rx_if #(.CORDW(CORDW)) bus ();

  frame_sig_rx #(.CORDW(CORDW), .H_RES(H), .V_RES(V)) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (bus)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // byte-wise CCITT reference: three bytes R, G, B
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [23:0] p);
    logic [15:0] r;
    r = c;
    for (int b = 2; b >= 0; b--) begin
      r = r ^ {p[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // record consumer side of the scoreboard
  always @(negedge clk_pix) begin
    if (rst_pix_n && bus.sig_valid && bus.sig_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got frame_no=%0d cnt=%0d", bus.sig_frame_no, bus.sig_pix_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = '{bus.sig_crc, bus.sig_pix_cnt, bus.sig_frame_no, bus.sig_geom_err, bus.sig_coord_err};
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL record got crc=%h cnt=%0d fno=%0d geom=%b coord=%b want crc=%h cnt=%0d fno=%0d geom=%b coord=%b",
                   mon_got.crc, mon_got.cnt, mon_got.fno, mon_got.geom, mon_got.coord,
                   mon_exp.crc, mon_exp.cnt, mon_exp.fno, mon_exp.geom, mon_exp.coord);
        end
      end
    end
  end

  // one pixel-clock cycle of stimulus, with the model updated alongside
  task automatic drive_cycle(input logic frame, input logic de, input int sx, input int sy, input logic [23:0] pix);
    if (frame && m_active) begin
      m_last = '{m_crc, 20'(m_cnt), 16'(m_frame_no), (m_cnt != HV), m_cerr};
      if (push_on_end) exp_q.push_back(m_last);
      m_frame_no++;
    end
    if (frame) begin
      m_active = 1'b1;
      m_crc    = 16'hFFFF;
      m_cnt    = 0;
      m_cerr   = 1'b0;
    end
    if (de && m_active) begin
      if (COORD_EN && ((sx != m_cnt % H) || (sy != m_cnt / H))) m_cerr = 1'b1;
      m_crc = model_crc(m_crc, pix);
      m_cnt++;
    end
    bus.in_frame = frame;
    bus.in_de    = de;
    bus.in_sx    = CORDW'(sx);
    bus.in_sy    = CORDW'(sy);
    {bus.in_r, bus.in_g, bus.in_b} = pix;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 0, 0, 24'h0);
  endtask

  task automatic frame_strobe(input logic de, input logic [23:0] pix);
    drive_cycle(1'b1, de, 0, 0, pix);
  endtask

  // mode 0 black, mode 1 random colour; bad_idx gets in_sx one too high
  task automatic send_pixels(input int first, input int npix, input int bad_idx, input int mode);
    logic [23:0] pix;
    int sx;
    for (int i = first; i < npix; i++) begin
      pix = (mode == 0) ? 24'h0 : 24'($urandom);
      sx  = i % H;
      if (i == bad_idx) sx = sx + 1;
      drive_cycle(1'b0, 1'b1, sx, i / H, pix);
      if (i % H == H - 1) idle();
    end
  endtask

  task automatic apply_reset();
    rst_pix_n  = 1'b0;
    m_active   = 1'b0;
    m_frame_no = 0;
    m_cnt      = 0;
    m_crc      = 16'hFFFF;
    m_cerr     = 1'b0;
    idle();
    idle();
    rst_pix_n = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    bus.sig_ready = 1'b1;
    push_on_end   = 1'b1;
    apply_reset();
    checks++;
    if ({bus.sig_valid, bus.sig_crc, bus.sig_pix_cnt, bus.sig_frame_no, bus.sig_geom_err,
         bus.sig_coord_err, bus.sig_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b crc=%h cnt=%0d fno=%0d geom=%b coord=%b ovr=%b want all 0",
               bus.sig_valid, bus.sig_crc, bus.sig_pix_cnt, bus.sig_frame_no, bus.sig_geom_err,
               bus.sig_coord_err, bus.sig_overrun);
    end
  endtask

  task automatic test_basic();
    send_pixels(0, 20, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL first_sof_no_record got=%b want=0", bus.sig_valid); end
    send_pixels(0, HV, -1, 0);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b want=1", bus.sig_valid); end
    checks++; if (bus.sig_pix_cnt !== 20'(HV)) begin errors++; $display("FAIL basic_cnt got=%0d want=%0d", bus.sig_pix_cnt, HV); end
    checks++; if (bus.sig_frame_no !== 16'd0) begin errors++; $display("FAIL basic_fno got=%0d want=0", bus.sig_frame_no); end
    checks++; if (bus.sig_geom_err !== 1'b0) begin errors++; $display("FAIL basic_geom got=%b want=0", bus.sig_geom_err); end
    checks++; if (bus.sig_crc !== m_last.crc) begin errors++; $display("FAIL basic_crc got=%h want=%h", bus.sig_crc, m_last.crc); end
    idle();
    checks++; if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got=%b want=0", bus.sig_valid); end
    send_pixels(0, HV, -1, 0);
  endtask

  task automatic test_short_frame();
    frame_strobe(1'b0, 24'h0);
    idle();
    send_pixels(0, HV - 1, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_pix_cnt !== 20'(HV - 1)) begin errors++; $display("FAIL short_cnt got=%0d want=%0d", bus.sig_pix_cnt, HV - 1); end
    checks++; if (bus.sig_geom_err !== 1'b1) begin errors++; $display("FAIL short_geom got=%b want=1", bus.sig_geom_err); end
    checks++; if (bus.sig_coord_err !== 1'b0) begin errors++; $display("FAIL short_coord got=%b want=0", bus.sig_coord_err); end
  endtask

  task automatic test_coord();
    send_pixels(0, HV, 4, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_coord_err !== COORD_EN) begin errors++; $display("FAIL coord_err got=%b want=%b", bus.sig_coord_err, COORD_EN); end
    checks++; if (bus.sig_geom_err !== 1'b0) begin errors++; $display("FAIL coord_geom got=%b want=0", bus.sig_geom_err); end
  endtask

  task automatic test_crc();
    logic [15:0] want;
    want = model_crc(16'hFFFF, 24'h123456);
    drive_cycle(1'b0, 1'b1, 0, 0, 24'h123456);
    idle();
    // closing strobe carries a pixel that must land in the next frame
    frame_strobe(1'b1, 24'hABCDEF);
    checks++; if (bus.sig_crc !== want) begin errors++; $display("FAIL crc_single got=%h want=%h", bus.sig_crc, want); end
    checks++; if (bus.sig_pix_cnt !== 20'd1) begin errors++; $display("FAIL crc_single_cnt got=%0d want=1", bus.sig_pix_cnt); end
    send_pixels(1, HV, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_pix_cnt !== 20'(HV)) begin errors++; $display("FAIL sof_pixel_cnt got=%0d want=%0d", bus.sig_pix_cnt, HV); end
    checks++; if (bus.sig_crc !== m_last.crc) begin errors++; $display("FAIL sof_pixel_crc got=%h want=%h", bus.sig_crc, m_last.crc); end
  endtask

  task automatic test_back_to_back();
    send_pixels(0, 5, -1, 1);
    frame_strobe(1'b0, 24'h0);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b want=1", bus.sig_valid); end
    checks++; if (bus.sig_pix_cnt !== 20'd0) begin errors++; $display("FAIL b2b_cnt got=%0d want=0", bus.sig_pix_cnt); end
    checks++; if (bus.sig_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b want=0", bus.sig_overrun); end
    idle();
    checks++; if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%b want=0", bus.sig_valid); end
  endtask

  task automatic test_overrun();
    apply_reset();
    frame_strobe(1'b0, 24'h0);
    send_pixels(0, HV, -1, 1);
    bus.sig_ready = 1'b0;
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got=%b want=0", bus.sig_overrun); end
    send_pixels(0, HV, -1, 1);
    push_on_end = 1'b0;
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want=1", bus.sig_overrun); end
    checks++; if (bus.sig_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got=%b want=1", bus.sig_valid); end
    send_pixels(0, HV, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_frame_no !== 16'd0) begin errors++; $display("FAIL ovr_hold_fno got=%0d want=0", bus.sig_frame_no); end
    push_on_end   = 1'b1;
    bus.sig_ready = 1'b1;
    idle();
    checks++; if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b want=0", bus.sig_valid); end
    send_pixels(0, HV, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_frame_no !== 16'd3) begin errors++; $display("FAIL ovr_next_fno got=%0d want=3", bus.sig_frame_no); end
    checks++; if (bus.sig_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b want=1", bus.sig_overrun); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.sig_ready = 1'b0;
    send_pixels(0, HV, -1, 1);
    push_on_end = 1'b0;
    frame_strobe(1'b0, 24'h0);
    send_pixels(0, 40, -1, 1);
    rst_pix_n = 1'b0;
    #2;
    checks++;
    if ({bus.sig_valid, bus.sig_crc, bus.sig_pix_cnt, bus.sig_frame_no, bus.sig_geom_err,
         bus.sig_coord_err, bus.sig_overrun} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got valid=%b crc=%h cnt=%0d fno=%0d ovr=%b want all 0",
               bus.sig_valid, bus.sig_crc, bus.sig_pix_cnt, bus.sig_frame_no, bus.sig_overrun);
    end
    push_on_end   = 1'b1;
    bus.sig_ready = 1'b1;
    apply_reset();
    send_pixels(40, 60, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_record got=%b want=0", bus.sig_valid); end
    send_pixels(0, HV, -1, 1);
    frame_strobe(1'b0, 24'h0);
    checks++; if (bus.sig_valid !== 1'b1) begin errors++; $display("FAIL midreset_record got=%b want=1", bus.sig_valid); end
    checks++; if (bus.sig_frame_no !== 16'd0) begin errors++; $display("FAIL midreset_fno got=%0d want=0", bus.sig_frame_no); end
    idle();
    idle();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_pix_n     = 1'b0;
    bus.in_frame  = 1'b0;
    bus.in_de     = 1'b0;
    bus.in_sx     = '0;
    bus.in_sy     = '0;
    bus.in_r      = 8'h0;
    bus.in_g      = 8'h0;
    bus.in_b      = 8'h0;
    bus.sig_ready = 1'b1;
    push_on_end   = 1'b1;
    m_last        = '0;

    test_reset();
    test_basic();
    test_short_frame();
    test_coord();
    test_crc();
    test_back_to_back();
    test_overrun();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_sig_rx.md
# frame_sig_rx

Pixel-stream sink that consumes the registered SDL/VGA output of the game top level (coordinates, data enable, frame strobe, 8-bit RGB) and produces one signature record per frame: CRC-16 over active pixels, active-pixel count, geometry/coordinate error flags and a frame number. It is the receiving end of the pixel stream. It sits beside the simulation harness and on the FPGA debug path, so regression runs compare frames without dumping images.

## Interface
- CORDW, 16, signed coordinate width of in_sx/in_sy
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame

- clk_pix  in  1  pixel clock; the only clock
- rst_pix_n  in  1  asynchronous active-low reset
- in_sx  in  CORDW  signed horizontal position of the current pixel
- in_sy  in  CORDW  signed vertical position of the current pixel
- in_de  in  1  pixel is active (high only in the visible area)
- in_frame  in  1  one-cycle strobe at start of frame
- in_r, in_g, in_b  in  8 each  pixel colour
- sig_valid  out  1  signature record available
- sig_ready  in  1  consumer accepts the record
- sig_crc  out  16  CRC-16 of the frame's active pixels
- sig_pix_cnt  out  20  active pixels counted in the frame; saturates at 2^20-1
- sig_frame_no  out  16  frame number, wraps
- sig_geom_err  out  1  pixel count differs from H_RES*V_RES
- sig_coord_err  out  1  at least one active pixel had unexpected coordinates
- sig_overrun  out  1  sticky: a finished frame was dropped because the record was still pending

## Operation
- FSM states: WAIT_SOF and ACCUM.
  - Reset enters WAIT_SOF. Pixels are ignored in WAIT_SOF.
  - The first in_frame moves to ACCUM and clears the accumulators. The partial frame before it is never reported.
- ACCUM, on each in_de cycle:
  - CRC update with the 24-bit word {in_r,in_g,in_b}, MSB first. CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR. All 24 bits are folded in a single cycle.
  - pix_cnt increments, saturating.
- Expected-coordinate tracker: exp_x and exp_y start at 0 at each in_frame.
  - Each in_de cycle compares in_sx==exp_x and in_sy==exp_y. A mismatch sets the per-frame coord error flag.
  - exp_x then increments. At H_RES-1 it wraps to 0 and exp_y increments.
- in_frame while in ACCUM is the frame end and the start of the next frame.
  - The finished accumulators go to the output record: geom_err=(pix_cnt!=H_RES*V_RES), and frame_no is the internal counter, which then increments.
  - The accumulators re-initialise in the same cycle.
- Output handshake (valid/ready):
  - A record is held stable while sig_valid && !sig_ready.
  - Transfer happens on sig_valid && sig_ready. sig_valid drops next cycle unless a new record loads.
  - A new record arriving while the previous one is pending and not transferring: the new record is dropped, the old one is held, sig_overrun is set. The frame counter still increments.
  - New record and transfer in the same cycle: the new record loads, sig_valid stays 1, no overrun.
- sig_overrun clears only on reset.

## Timing
- All outputs are registered. Reset values: sig_valid=0, sig_crc=0, sig_pix_cnt=0, sig_frame_no=0, all error flags 0. The internal frame counter resets to 0 and the accumulators are cleared.
- Latency: sig_valid rises exactly 1 cycle after the in_frame edge that closes a frame.
- in_frame and in_de high in the same cycle: the pixel belongs to the new frame. The finished record excludes it, and the new accumulators include it, so the CRC starts from 0xFFFF updated by that pixel.
- Reset asserted mid-frame: immediate return to WAIT_SOF. A pending record is lost.
- The block never stalls the input. The stream has no backpressure; loss is reported only through sig_overrun.

## Configuration
- FRAME_SIG_COORD_CHECK_EN defined: the expected-coordinate tracker and comparators are built, and sig_coord_err operates as above.
- Not defined: the tracker is omitted, sig_coord_err is tied to 0, and in_sx/in_sy are unused. CRC, count, geometry and handshake are unchanged.

## Test plan
- Reset, then two full 640x480 frames of black with sig_ready=1 → one record: pix_cnt=307200, geom_err=0, coord_err=0, frame_no=0. sig_valid high for exactly 1 cycle, 1 cycle after the second in_frame.
- Frame with a 639-pixel last line → pix_cnt=307199, geom_err=1, and coord_err stays 0 when the coordinates are consistent.
- Frame with one pixel reporting in_sx=5 where exp_x=4 (FRAME_SIG_COORD_CHECK_EN defined) → coord_err=1. Same stimulus with the macro undefined → coord_err=0.
- Frame of a single non-black pixel pattern → sig_crc matches a bench CRC-16-CCITT model (0x1021, init 0xFFFF, 24 bits per pixel).
- sig_ready=0 across three frame ends → the first record is held with frame_no=0, sig_overrun=1 after the second frame end, and frame_no=3 is reported on the next record after ready returns.
- rst_pix_n pulsed low mid-frame with a record pending → all outputs 0 immediately. No record is produced until two further in_frame strobes.
